// File: rtl/fp_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fp_dispatch (with fp_dispatch_pkg and fp_dispatch_fifo)
// Brief    : Issue/writeback front end for fp_top with tag tracking,
//            credit-based issue and in-order tagged responses.
// Revision : 1.0 - initial release
// ============================================================================

package fp_dispatch_pkg;
  typedef enum logic [1:0] {FP32 = 2'd0, FP64 = 2'd1, FP16 = 2'd2, FP16ALT = 2'd3} fp_format_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      default: return 16;
    endcase
  endfunction

  typedef enum logic [3:0] {
    FMADD = 4'd0, FNMSUB = 4'd1, ADD = 4'd2, MUL = 4'd3, DIV = 4'd4,
    SQRT = 4'd5, SGNJ = 4'd6, MINMAX = 4'd7, CMP = 4'd8, CLASSIFY = 4'd9,
    F2F = 4'd10, F2I = 4'd11, I2F = 4'd12, CPKAB = 4'd13, CPKCD = 4'd14
  } float_op_e;

  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

// Circular FIFO; the extra pointer bit separates full from empty, head reads 0 when empty.
module fp_dispatch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

module fp_dispatch
  import fp_dispatch_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT = FP32,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TAG_WIDTH = 5,
  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  float_op_e            req_op_i,
  input  logic [1:0]           req_mod_i,
  input  roundmode_e           req_rnd_i,
  input  logic [FP_WIDTH-1:0]  req_a_i,
  input  logic [FP_WIDTH-1:0]  req_b_i,
  input  logic [FP_WIDTH-1:0]  req_c_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic                 fpu_start_o,
  input  logic                 fpu_ready_i,
  output float_op_e            fpu_op_o,
  output logic [1:0]           fpu_mod_o,
  output roundmode_e           fpu_rnd_o,
  output logic [FP_WIDTH-1:0]  fpu_a_o,
  output logic [FP_WIDTH-1:0]  fpu_b_o,
  output logic [FP_WIDTH-1:0]  fpu_c_o,
  input  logic                 fpu_valid_i,
  input  logic [FP_WIDTH-1:0]  fpu_result_i,
  input  status_t              fpu_flags_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [FP_WIDTH-1:0]  rsp_result_o,
  output status_t              rsp_flags_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output status_t              fflags_o,
  input  logic                 fflags_clr_i,
  output logic                 err_o
);
  localparam int unsigned RQW = $clog2(REQ_DEPTH) + 1;
  localparam int unsigned CW  = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    float_op_e            op;
    logic [1:0]           mod;
    roundmode_e           rnd;
    logic [FP_WIDTH-1:0]  a;
    logic [FP_WIDTH-1:0]  b;
    logic [FP_WIDTH-1:0]  c;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [FP_WIDTH-1:0]  result;
    status_t              flags;
    logic [TAG_WIDTH-1:0] tag;
  } rsp_t;

  req_t                 req_in;
  req_t                 req_head;
  rsp_t                 rsp_in;
  rsp_t                 rsp_head;
  logic [TAG_WIDTH-1:0] tag_head;
  logic [RQW-1:0]       req_count;
  logic [CW-1:0]        tag_count;
  logic [CW-1:0]        rsp_count;
  logic [CW-1:0]        inflight;
  logic                 req_empty;
  logic                 tag_empty;
  logic                 rsp_empty;
  logic                 req_push;
  logic                 issue;
  logic                 capture;
  logic                 rsp_pop;
  logic                 credit_ok;
  status_t              pop_flags;

  assign req_empty   = (req_count == '0);
  assign tag_empty   = (tag_count == '0);
  assign rsp_empty   = (rsp_count == '0);
  assign req_ready_o = (req_count != RQW'(REQ_DEPTH));
  assign req_push    = req_valid_i && req_ready_o;

  // Every issued op must already own a response slot, so the FPU is never stalled.
  assign credit_ok = ({1'b0, inflight} + {1'b0, rsp_count}) < (CW+1)'(RSP_DEPTH);
  assign issue     = !req_empty && fpu_ready_i && credit_ok;
  assign capture   = fpu_valid_i && !tag_empty;
  assign rsp_pop   = !rsp_empty && rsp_ready_i;

  assign req_in = '{op: req_op_i, mod: req_mod_i, rnd: req_rnd_i,
                    a: req_a_i, b: req_b_i, c: req_c_i, tag: req_tag_i};
  assign rsp_in = '{result: fpu_result_i, flags: fpu_flags_i, tag: tag_head};

  fp_dispatch_fifo #(.DEPTH(REQ_DEPTH), .WIDTH($bits(req_t))) u_req_fifo (
    .clk(clk_i), .rst(rst_i), .push(req_push), .pop(issue),
    .wdata(req_in), .rdata(req_head), .count(req_count)
  );

  fp_dispatch_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(TAG_WIDTH)) u_tag_fifo (
    .clk(clk_i), .rst(rst_i), .push(issue), .pop(capture),
    .wdata(req_head.tag), .rdata(tag_head), .count(tag_count)
  );

  fp_dispatch_fifo #(.DEPTH(RSP_DEPTH), .WIDTH($bits(rsp_t))) u_rsp_fifo (
    .clk(clk_i), .rst(rst_i), .push(capture), .pop(rsp_pop),
    .wdata(rsp_in), .rdata(rsp_head), .count(rsp_count)
  );

  assign pop_flags = rsp_pop ? rsp_head.flags : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= '0;
      fflags_o <= '0;
      err_o    <= 1'b0;
    end else begin
      case ({issue, capture})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      fflags_o <= fflags_clr_i ? pop_flags : (fflags_o | pop_flags);
      if (fpu_valid_i && tag_empty) err_o <= 1'b1;
    end
  end

  assign fpu_start_o  = issue;
  assign fpu_op_o     = req_head.op;
  assign fpu_mod_o    = req_head.mod;
  assign fpu_rnd_o    = req_head.rnd;
  assign fpu_a_o      = req_head.a;
  assign fpu_b_o      = req_head.b;
  assign fpu_c_o      = req_head.c;
  assign rsp_valid_o  = !rsp_empty;
  assign rsp_result_o = rsp_head.result;
  assign rsp_flags_o  = rsp_head.flags;
  assign rsp_tag_o    = rsp_head.tag;
endmodule

`default_nettype wire

// File: tb/tb_fp_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_dispatch
// Brief    : Directed and randomized bench for fp_dispatch with an FPU emulator
//            and a queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_dispatch;
  import fp_dispatch_pkg::*;

  localparam int REQ_DEPTH = 4;
  localparam int RSP_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o;
  float_op_e   req_op_i;
  logic [1:0]  req_mod_i;
  roundmode_e  req_rnd_i;
  logic [31:0] req_a_i, req_b_i, req_c_i;
  logic [4:0]  req_tag_i;
  logic        fpu_start_o, fpu_ready_i;
  float_op_e   fpu_op_o;
  logic [1:0]  fpu_mod_o;
  roundmode_e  fpu_rnd_o;
  logic [31:0] fpu_a_o, fpu_b_o, fpu_c_o;
  logic        fpu_valid_i;
  logic [31:0] fpu_result_i;
  status_t     fpu_flags_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  status_t     rsp_flags_o;
  logic [4:0]  rsp_tag_o;
  status_t     fflags_o;
  logic        fflags_clr_i, err_o;

  always #5 clk_i = ~clk_i;

  fp_dispatch #(.FP_FORMAT(FP32), .REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TAG_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_mod_i(req_mod_i), .req_rnd_i(req_rnd_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_c_i(req_c_i), .req_tag_i(req_tag_i),
    .fpu_start_o(fpu_start_o), .fpu_ready_i(fpu_ready_i), .fpu_op_o(fpu_op_o),
    .fpu_mod_o(fpu_mod_o), .fpu_rnd_o(fpu_rnd_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o),
    .fpu_c_o(fpu_c_o), .fpu_valid_i(fpu_valid_i), .fpu_result_i(fpu_result_i),
    .fpu_flags_i(fpu_flags_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_flags_o(rsp_flags_o), .rsp_tag_o(rsp_tag_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .err_o(err_o)
  );

  typedef struct packed {
    float_op_e   op;
    logic [1:0]  mod;
    roundmode_e  rnd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  tag;
  } req_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic [4:0]  tag;
  } rsp_t;

  typedef struct {
    int          due;
    logic [31:0] result;
    logic [4:0]  flags;
  } pend_t;

  // Reference model state: plain queues of what is buffered and in flight.
  req_t       m_req[$];
  logic [4:0] m_tag[$];
  rsp_t       m_rsp[$];
  logic [4:0] m_fflags = '0;
  logic       m_err = 1'b0;

  // FPU emulator state.
  pend_t       pend[$];
  int          last_due = 0;
  int          emu_lat = 2;
  logic        emu_fix_en = 1'b0;
  logic [31:0] emu_fix_val = '0;
  logic        emu_rand_flags = 1'b0;
  logic [4:0]  emu_flags_q[$];

  // Stimulus for the next cycle.
  logic s_req_valid = 1'b0, s_fpu_ready = 1'b1, s_rsp_ready = 1'b1, s_clr = 1'b0, s_spur = 1'b0;
  req_t s_req = '0;

  // Observation logs.
  int          cyc = 0;
  int          start_cyc[$];
  logic [31:0] start_a[$];
  logic [31:0] start_b[$];
  rsp_t        rsp_log[$];
  int          rsp_cyc[$];
  int          acc_cnt = 0, start_cnt = 0;
  logic        last_acc = 1'b0;

  int n_checks = 0, n_pass = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic req_t mk(int tag, logic [31:0] a, logic [31:0] b, logic [31:0] c);
    req_t r;
    r.op  = float_op_e'($urandom_range(0, 14));
    r.mod = 2'($urandom_range(0, 3));
    r.rnd = roundmode_e'($urandom_range(0, 4));
    r.a = a; r.b = b; r.c = c;
    r.tag = 5'(tag);
    return r;
  endfunction

  function automatic logic exp_start();
    return (m_req.size() > 0) && s_fpu_ready && (m_tag.size() + m_rsp.size() < RSP_DEPTH);
  endfunction

  task automatic compare();
    req_t h;
    rsp_t r;
    h = (m_req.size() > 0) ? m_req[0] : '0;
    r = (m_rsp.size() > 0) ? m_rsp[0] : '0;
    chk("req_ready", 64'(req_ready_o), 64'(m_req.size() < REQ_DEPTH));
    chk("fpu_start", 64'(fpu_start_o), 64'(exp_start()));
    chk("fpu_op", 64'(fpu_op_o), 64'(h.op));
    chk("fpu_mod", 64'(fpu_mod_o), 64'(h.mod));
    chk("fpu_rnd", 64'(fpu_rnd_o), 64'(h.rnd));
    chk("fpu_abc", {fpu_a_o, fpu_b_o ^ fpu_c_o}, {h.a, h.b ^ h.c});
    chk("fpu_c", 64'(fpu_c_o), 64'(h.c));
    chk("rsp_valid", 64'(rsp_valid_o), 64'(m_rsp.size() > 0));
    chk("rsp_data", 64'({rsp_result_o, rsp_flags_o, rsp_tag_o}), 64'(r));
    chk("fflags", 64'(fflags_o), 64'(m_fflags));
    chk("err", 64'(err_o), 64'(m_err));
  endtask

  task automatic observe();
    pend_t p;
    last_acc = req_valid_i && req_ready_o;
    if (last_acc) acc_cnt++;
    if (fpu_start_o) begin
      start_cnt++;
      start_cyc.push_back(cyc);
      start_a.push_back(fpu_a_o);
      start_b.push_back(fpu_b_o);
      p.due = (cyc + emu_lat > last_due) ? cyc + emu_lat : last_due + 1;
      p.result = emu_fix_en ? emu_fix_val : ((fpu_a_o ^ {fpu_b_o[15:0], fpu_b_o[31:16]}) + fpu_c_o + 32'(cyc));
      if (emu_flags_q.size() > 0) p.flags = emu_flags_q.pop_front();
      else p.flags = emu_rand_flags ? 5'($urandom_range(0, 31)) : 5'd0;
      last_due = p.due;
      pend.push_back(p);
    end
    if (rsp_valid_o && rsp_ready_i) begin
      rsp_log.push_back({rsp_result_o, rsp_flags_o, rsp_tag_o});
      rsp_cyc.push_back(cyc);
    end
  endtask

  task automatic model_step();
    logic       st, acc, cap, pop;
    logic [4:0] f;
    st  = exp_start();
    acc = s_req_valid && (m_req.size() < REQ_DEPTH);
    cap = fpu_valid_i && (m_tag.size() > 0);
    pop = s_rsp_ready && (m_rsp.size() > 0);
    if (fpu_valid_i && m_tag.size() == 0) m_err = 1'b1;
    f = pop ? m_rsp[0].flags : 5'd0;
    if (pop) void'(m_rsp.pop_front());
    m_fflags = s_clr ? f : (m_fflags | f);
    if (cap) m_rsp.push_back({fpu_result_i, fpu_flags_i, m_tag.pop_front()});
    if (st) begin
      m_tag.push_back(m_req[0].tag);
      void'(m_req.pop_front());
    end
    if (acc) m_req.push_back(s_req);
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
    req_valid_i = s_req_valid;
    req_op_i = s_req.op; req_mod_i = s_req.mod; req_rnd_i = s_req.rnd;
    req_a_i = s_req.a; req_b_i = s_req.b; req_c_i = s_req.c; req_tag_i = s_req.tag;
    fpu_ready_i = s_fpu_ready;
    rsp_ready_i = s_rsp_ready;
    fflags_clr_i = s_clr;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      fpu_valid_i = 1'b1;
      fpu_result_i = pend[0].result;
      fpu_flags_i = status_t'(pend[0].flags);
      void'(pend.pop_front());
    end else begin
      fpu_valid_i = s_spur;
      fpu_result_i = '0;
      fpu_flags_i = '0;
    end
    #1;
    compare();
    observe();
    model_step();
    cyc++;
  endtask

  task automatic idle(int n);
    s_req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic offer(req_t r);
    int k;
    s_req = r;
    s_req_valid = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_acc && k < 50);
    if (!last_acc) chk("offer_timeout", 64'(0), 64'(1));
    s_req_valid = 1'b0;
  endtask

  task automatic clear_logs();
    start_cyc.delete(); start_a.delete(); start_b.delete();
    rsp_log.delete(); rsp_cyc.delete();
    acc_cnt = 0; start_cnt = 0;
  endtask

  task automatic reset_checks(string tagname);
    chk({tagname, "_start"}, 64'(fpu_start_o), 64'(0));
    chk({tagname, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
    chk({tagname, "_fflags"}, 64'(fflags_o), 64'(0));
    chk({tagname, "_err"}, 64'(err_o), 64'(0));
    chk({tagname, "_req_ready"}, 64'(req_ready_o), 64'(1));
    chk({tagname, "_fpu_a"}, 64'(fpu_a_o), 64'(0));
    chk({tagname, "_rsp_data"}, 64'({rsp_result_o, rsp_tag_o}), 64'(0));
  endtask

  task automatic drive_idle_inputs();
    req_valid_i = 1'b0; req_op_i = FMADD; req_mod_i = '0; req_rnd_i = RNE;
    req_a_i = '0; req_b_i = '0; req_c_i = '0; req_tag_i = '0;
    fpu_ready_i = 1'b0; fpu_valid_i = 1'b0; fpu_result_i = '0; fpu_flags_i = '0;
    rsp_ready_i = 1'b0; fflags_clr_i = 1'b0;
  endtask

  initial begin
    int c0, tag, k;
    req_t cur;

    rst_i = 1'b1;
    drive_idle_inputs();
    #1;
    reset_checks("reset");
    @(negedge clk_i); @(negedge clk_i); #1 rst_i = 1'b0;

    // Single FADD, FPU latency 2.
    emu_lat = 2; emu_fix_en = 1'b1; emu_fix_val = 32'h4040_0000;
    clear_logs();
    c0 = cyc;
    offer(mk(3, 32'h3F80_0000, 32'h4000_0000, 32'h0));
    idle(6);
    emu_fix_en = 1'b0;
    chk("fadd_start_count", 64'(start_cyc.size()), 64'(1));
    chk("fadd_start_cycle", 64'(start_cyc[0] - c0), 64'(1));
    chk("fadd_operands", {start_a[0], start_b[0]}, {32'h3F80_0000, 32'h4000_0000});
    chk("fadd_rsp_cycle", 64'(rsp_cyc[0] - c0), 64'(4));
    chk("fadd_rsp", 64'(rsp_log[0]), 64'({32'h4040_0000, 5'h00, 5'd3}));

    // Back-to-back stream of four.
    clear_logs();
    c0 = cyc;
    for (int t = 0; t < 4; t++) offer(mk(t, $urandom, $urandom, $urandom));
    idle(8);
    chk("b2b_start_count", 64'(start_cyc.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("b2b_start_cycle", 64'(start_cyc[i] - c0), 64'(i + 1));
      chk("b2b_rsp_cycle", 64'(rsp_cyc[i] - c0), 64'(i + 4));
      chk("b2b_rsp_tag", 64'(rsp_log[i].tag), 64'(i));
    end

    // Backpressure: response side stalled, ten requests offered.
    clear_logs();
    s_rsp_ready = 1'b0;
    tag = 0;
    cur = mk(0, $urandom, $urandom, $urandom);
    for (int i = 0; i < 20; i++) begin
      s_req_valid = (tag < 10); s_req = cur;
      tick();
      if (last_acc) begin tag++; cur = mk(tag, $urandom, $urandom, $urandom); end
    end
    chk("bp_starts", 64'(start_cnt), 64'(4));
    chk("bp_accepted", 64'(acc_cnt), 64'(8));
    s_rsp_ready = 1'b1;
    k = 0;
    while ((tag < 10 || rsp_log.size() < 10) && k < 80) begin
      s_req_valid = (tag < 10); s_req = cur;
      tick();
      if (last_acc) begin tag++; cur = mk(tag, $urandom, $urandom, $urandom); end
      k++;
    end
    s_req_valid = 1'b0;
    chk("bp_rsp_count", 64'(rsp_log.size()), 64'(10));
    for (int i = 0; i < 10; i++) chk("bp_rsp_order", 64'(rsp_log[i].tag), 64'(i));

    // Sticky flags and clear-with-pop.
    emu_flags_q.push_back(5'h01);
    emu_flags_q.push_back(5'h05);
    offer(mk(20, $urandom, $urandom, $urandom));
    offer(mk(21, $urandom, $urandom, $urandom));
    idle(8);
    chk("fflags_or", 64'(fflags_o), 64'(5'h05));
    emu_flags_q.push_back(5'h08);
    s_rsp_ready = 1'b0;
    offer(mk(22, $urandom, $urandom, $urandom));
    k = 0;
    while (!rsp_valid_o && k < 50) begin tick(); k++; end
    if (!rsp_valid_o) chk("flags_wait_timeout", 64'(0), 64'(1));
    s_rsp_ready = 1'b1; s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    tick();
    chk("fflags_clr_pop", 64'(fflags_o), 64'(5'h08));

    // Spurious valid with nothing in flight.
    idle(4);
    s_spur = 1'b1;
    tick();
    s_spur = 1'b0;
    tick();
    chk("spur_err", 64'(err_o), 64'(1));
    chk("spur_no_rsp", 64'(rsp_valid_o), 64'(0));

    // Reset with two queued and two in flight.
    emu_lat = 30;
    s_fpu_ready = 1'b1;
    offer(mk(10, $urandom, $urandom, $urandom));
    offer(mk(11, $urandom, $urandom, $urandom));
    offer(mk(12, $urandom, $urandom, $urandom));
    s_fpu_ready = 1'b0;
    offer(mk(13, $urandom, $urandom, $urandom));
    idle(1);
    chk("pre_reset_queued", 64'(m_req.size()), 64'(2));
    chk("pre_reset_inflight", 64'(m_tag.size()), 64'(2));
    @(negedge clk_i);
    #1;
    drive_idle_inputs();
    rst_i = 1'b1;
    #1;
    reset_checks("midreset");
    m_req.delete(); m_tag.delete(); m_rsp.delete(); m_fflags = '0; m_err = 1'b0;
    pend.delete(); last_due = 0;
    @(negedge clk_i); #1 rst_i = 1'b0;
    emu_lat = 2; s_fpu_ready = 1'b1; s_rsp_ready = 1'b1;
    clear_logs();
    offer(mk(7, $urandom, $urandom, $urandom));
    idle(8);
    chk("post_reset_rsp_count", 64'(rsp_log.size()), 64'(1));
    chk("post_reset_tag", 64'(rsp_log[0].tag), 64'(7));
    chk("post_reset_err", 64'(err_o), 64'(0));

    // Randomized traffic.
    emu_rand_flags = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      s_req_valid = ($urandom_range(0, 99) < 60);
      s_req = mk($urandom_range(0, 31), $urandom, $urandom, $urandom);
      s_fpu_ready = ($urandom_range(0, 99) < 85);
      s_rsp_ready = ($urandom_range(0, 99) < 70);
      s_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 3) emu_lat = $urandom_range(1, 5);
      tick();
    end
    s_req_valid = 1'b0; s_fpu_ready = 1'b1; s_rsp_ready = 1'b1; s_clr = 1'b0;
    k = 0;
    while ((m_req.size() + m_tag.size() + m_rsp.size() + pend.size()) > 0 && k < 300) begin
      tick();
      k++;
    end
    chk("random_drained", 64'(m_req.size() + m_tag.size() + m_rsp.size() + pend.size()), 64'(0));
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fp_dispatch.md
# fp_dispatch

CPU-side issue and writeback front end for `fp_top`. It accepts tagged FP operation requests over a valid/ready interface and buffers them in a request FIFO. It drives `fp_top` with a one-cycle start pulse whenever the unit is ready and result space is reserved. It pairs each returned `valid_o` result with its tag and presents in-order responses over a second valid/ready interface, accumulating sticky `fflags`.

## Interface
Parameters:
- `FP_FORMAT`, default `FP32`: operand format; `FP_WIDTH = fp_width(FP_FORMAT)`.
- `REQ_DEPTH`, default 4: request FIFO entries; power of two, ≥ 2.
- `RSP_DEPTH`, default 4: response FIFO entries; also the maximum number of in-flight plus buffered results. Power of two, ≥ 2.
- `TAG_WIDTH`, default 5: request tag width.

Ports:
- `clk_i`, in, 1: the only clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request accepted when high together with `req_valid_i`.
- `req_op_i`, in, `float_op_e`: operation.
- `req_mod_i`, in, 2: op modifier.
- `req_rnd_i`, in, `roundmode_e`: rounding mode.
- `req_a_i`, `req_b_i`, `req_c_i`, in, `FP_WIDTH`: operands.
- `req_tag_i`, in, `TAG_WIDTH`: request tag.
- `fpu_start_o`, out, 1: start pulse to `fp_top.start_i`.
- `fpu_ready_i`, in, 1: from `fp_top.ready_o`.
- `fpu_op_o`, `fpu_mod_o`, `fpu_rnd_o`, `fpu_a_o`, `fpu_b_o`, `fpu_c_o`, out: to the matching `fp_top` inputs.
- `fpu_valid_i`, in, 1: from `fp_top.valid_o`.
- `fpu_result_i`, in, `FP_WIDTH`: from `fp_top.result_o`.
- `fpu_flags_i`, in, `status_t`: from `fp_top.flags_o`.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response consumer ready.
- `rsp_result_o`, out, `FP_WIDTH`: response result.
- `rsp_flags_o`, out, `status_t`: response flags.
- `rsp_tag_o`, out, `TAG_WIDTH`: response tag.
- `fflags_o`, out, `status_t`: sticky accumulated flags.
- `fflags_clr_i`, in, 1: clear `fflags_o`.
- `err_o`, out, 1: sticky protocol error.

## Operation
- **Request FIFO** (`REQ_DEPTH`): stores {op, mod, rnd, a, b, c, tag}.
  - Push on `req_valid_i & req_ready_o`.
  - `req_ready_o = !req_full`. It is combinational from the registered count, so it reads 1 while reset is asserted.
  - No write-through: an entry pushed in cycle N is issuable no earlier than N+1.
- **Credit counter** `inflight` (0..`RSP_DEPTH`) counts issued operations whose results have not yet returned.
- **Issue rule:** `fpu_start_o = !req_empty & fpu_ready_i & (inflight + rsp_count < RSP_DEPTH)`.
  - When high, `fpu_*_o` carry the FIFO head in that same cycle.
  - The head pops, and its tag is pushed into the tag FIFO (depth `RSP_DEPTH`).
  - When `fpu_start_o` is low, `fpu_*_o` still show the head, or zeros when the FIFO is empty.
- **Capture:** on `fpu_valid_i` with the tag FIFO non-empty, push {`fpu_result_i`, `fpu_flags_i`, tag-FIFO head} into the response FIFO and pop the tag FIFO.
  - The credit rule guarantees the response FIFO has space. The FPU output is never backpressured.
- **Spurious valid:** `fpu_valid_i` with the tag FIFO empty sets `err_o` (sticky until reset). Nothing is pushed.
- **`inflight` update:** +1 on issue, −1 on capture. Both in the same cycle leave it unchanged.
- **Response FIFO** (`RSP_DEPTH`):
  - `rsp_valid_o = !rsp_empty`; `rsp_*_o` show the head.
  - Pop on `rsp_valid_o & rsp_ready_i`.
  - A capture and a pop in the same cycle are both performed.
- **`fflags_o` update**, with `f` = head flags if popped this cycle, else 0:
  - When `fflags_clr_i` is high: next = `f`.
  - Otherwise: next = `fflags_o | f`.
- **Ordering:** responses leave in issue order.
- **Reset:** `rst_i` clears all FIFOs, `inflight`, `fflags_o` and `err_o` immediately, regardless of in-flight operations. `fp_top` shares `rst_i`, so no stale result arrives after reset.

## Timing
- Reset values: `fpu_start_o`=0, `rsp_valid_o`=0, `fflags_o`=0, `err_o`=0, `req_ready_o`=1, all data outputs 0.
- Request accepted in cycle N → earliest `fpu_start_o` in N+1.
- `fpu_valid_i` in cycle M → `rsp_valid_o` in M+1.
- Minimum end-to-end latency = FPU latency + 2.
- Sustained throughput: one operation per cycle while `fpu_ready_i` is high and `rsp_ready_i` is high.
- `fpu_start_o` is never high for a cycle in which `fpu_ready_i` is low.
- Credit boundary: at `inflight + rsp_count == RSP_DEPTH`, issue stalls. A response pop in cycle K allows issue in K+1, not K.
- FIFO pointers wrap modulo depth. Full and empty are distinguished by an extra pointer bit.

## Test plan
- **Single FADD:** tag 3, a=0x3F800000, b=0x40000000, FPU returns 0x40400000 with flags 0 in cycle 3 → `fpu_start_o` in cycle 1 carrying those operands; `rsp_valid_o` in cycle 4 with result 0x40400000, tag 3, flags 0.
- **Back-to-back stream:** 4 requests with tags 0..3, FPU pipelined with latency 2, `rsp_ready_i`=1 → 4 consecutive starts in cycles 1–4; responses with tags 0,1,2,3 in cycles 4–7.
- **Backpressure:** `rsp_ready_i`=0, 10 requests offered → exactly 4 starts; `req_ready_o` drops after 8 accepted. Raising `rsp_ready_i` drains all 10 responses in tag order with no loss.
- **Flags:**
  - Responses with flags 0x01 then 0x05 → `fflags_o`=0x05.
  - Then `fflags_clr_i` in the same cycle as popping a 0x08 response → `fflags_o`=0x08.
- **Spurious valid:** `fpu_valid_i`=1 with nothing in flight → `err_o`=1 next cycle; `rsp_valid_o` stays 0.
- **Reset mid-op:** assert `rst_i` with 2 requests queued and 2 in flight → all outputs at their reset values immediately. After release, a new request completes normally with `err_o`=0.
